// File: rtl/rec_pkg.sv
// Shared types and width helpers for the order-driven transfer unit.
// Used by rec_order_xfer and its output register.
package rec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } state_t;

  function automatic int clog2p1(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int cnt_w(input int max_orders);
    return clog2p1(max_orders);
  endfunction

  function automatic int img_w(input int order_imgs);
    return clog2p1(order_imgs);
  endfunction

endpackage

// File: rtl/rec_out_reg.sv
// Single-entry AXI output register holding {last, data}.
// Loads on accept, holds under back-pressure, drops valid on handshake.
module rec_out_reg #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rec_order_xfer.sv
// Order-driven transfer unit: moves ORDER_IMGS buffer words per queued
// order to the PS AXI-Stream port, TLAST on the final word of each order.
module rec_order_xfer
  import rec_pkg::*;
#(
  parameter int DATA_W     = 25,
  parameter int ORDER_IMGS = 50,
  parameter int MAX_ORDERS = 5,
  localparam int CNT_W     = cnt_w(MAX_ORDERS),
  localparam int IMG_W     = img_w(ORDER_IMGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_en,
  input  logic              order_come,
  input  logic              buf_valid,
  input  logic [DATA_W-1:0] buf_in,
  output logic              send_enB,
  output logic              axi_tvalid,
  output logic [DATA_W-1:0] axi_tdata,
  output logic              axi_tlast,
  input  logic              axi_tready,
  output logic              order_full,
  output logic              order_drop,
  output logic              no_order,
  output logic              sending,
  output logic [CNT_W-1:0]  orders_pending
);

  state_t            state;
  logic [CNT_W-1:0]  order_count;
  logic [CNT_W-1:0]  count_nxt;
  logic [IMG_W-1:0]  rd_cnt;
  logic [IMG_W-1:0]  wr_cnt;
  logic [IMG_W-1:0]  load_idx;
  logic [DATA_W:0]   out_q;
  logic              hs;
  logic              finish;
  logic              accept;
  logic              chain;
  logic              last_word;

  assign hs     = axi_tvalid && axi_tready;
  assign finish = hs && axi_tlast;

  assign order_full     = order_count == CNT_W'(MAX_ORDERS);
  assign no_order       = order_count == '0;
  assign sending        = state != IDLE;
  assign orders_pending = order_count;

  always_comb begin
    count_nxt = order_count;
    if (order_come && !finish && !order_full)
      count_nxt = order_count + 1'b1;
    else if (!order_come && finish)
      count_nxt = order_count - 1'b1;
  end

  // The first word of a queued order is read in the finish cycle,
  // so consecutive orders stream with no gap on the AXI side.
  assign chain = (state == DRAIN) && finish && rec_en &&
                 (count_nxt != '0);

  assign send_enB = ((state == XFER) && rec_en &&
                     (!axi_tvalid || axi_tready)) || chain;
  assign accept   = send_enB && buf_valid;

  assign load_idx  = (state == DRAIN) ? '0 : rd_cnt;
  assign last_word = load_idx == IMG_W'(ORDER_IMGS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      order_count <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      order_drop  <= 1'b0;
    end else begin
      order_count <= count_nxt;
      order_drop  <= order_come && order_full && !finish;
      if (hs)
        wr_cnt <= finish ? '0 : wr_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (rec_en && order_count != '0) begin
            state  <= XFER;
            rd_cnt <= '0;
            wr_cnt <= '0;
          end
        end
        XFER: begin
          if (accept) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (last_word)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (finish) begin
            rd_cnt <= accept ? IMG_W'(1) : '0;
            if (!chain)
              state <= IDLE;
            else if (accept && last_word)
              state <= DRAIN;
            else
              state <= XFER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rec_out_reg #(
    .W(DATA_W + 1)
  ) u_out (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .ready(axi_tready),
    .d    ({last_word, buf_in}),
    .valid(axi_tvalid),
    .q    (out_q)
  );

  assign axi_tdata = out_q[DATA_W-1:0];
  assign axi_tlast = out_q[DATA_W] && axi_tvalid;

  a_order_len : assert property (@(posedge clk) disable iff (!rst_n)
    finish |-> wr_cnt == IMG_W'(ORDER_IMGS - 1));

endmodule
